// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Step counter must hold the value WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_seq_unit_if.sv
// Start/busy/done handshake and operand/result bus between the EX stage and the multiplier.
interface mul_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, dataA, dataB,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, dataA, dataB,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_ctrl.sv
// Sequencing FSM and step counter for mul_seq_unit.
//   state | meaning
//   IDLE  | waiting for start; accepts a new multiply
//   RUN   | one shift-add step per cycle, WIDTH steps total
//   DONE  | result valid on hi/lo, done pulses for one cycle
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic accept_o,
    output logic run_step_o,
    output logic load_result_o,
    output logic busy_o,
    output logic done_o
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [1:0]    IDLE = ST_IDLE;
    localparam logic [1:0]    RUN  = ST_RUN;
    localparam logic [1:0]    DONE = ST_DONE;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign accept_o      = (state_q == IDLE) && start_i;
    assign run_step_o    = (state_q == RUN);
    assign load_result_o = (state_q == RUN) && (cnt_q == LAST);
    assign busy_o        = (state_q == RUN) || (state_q == DONE);
    assign done_o        = (state_q == DONE);

endmodule

// File: rtl/mul_seq_unit.sv
// Multi-cycle shift-add multiplier producing a 2*WIDTH product into HI/LO.
// Signed MULT support is built only when MUL_SIGNED_EN is defined.
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_unit_if.slave bus
);
    logic accept, run_step, load_result;

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] res_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] stepped;
    logic [WIDTH-1:0]   cap_a, cap_b;
    logic               sign_q, sign_d;

    mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .start_i       (bus.start),
        .accept_o      (accept),
        .run_step_o    (run_step),
        .load_result_o (load_result),
        .busy_o        (bus.busy),
        .done_o        (bus.done)
    );

`ifdef MUL_SIGNED_EN
    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
    always_comb begin
        cap_a  = (bus.is_signed && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
        cap_b  = (bus.is_signed && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
        sign_d = accept ? (bus.is_signed && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1])) : sign_q;
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = bus.is_signed;
    always_comb begin
        cap_a  = bus.dataA;
        cap_b  = bus.dataB;
        sign_d = 1'b0;
    end
`endif

    always_comb begin
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        stepped = {sum, prod_q[WIDTH-1:1]};
        res_d   = sign_q ? -stepped : stepped;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        if (accept) begin
            mcand_d = cap_a;
            prod_d  = {{WIDTH{1'b0}}, cap_b};
        end else if (run_step) begin
            prod_d  = stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            sign_q  <= sign_d;
            if (load_result) begin
                hi_q <= res_d[2*WIDTH-1:WIDTH];
                lo_q <= res_d[WIDTH-1:0];
            end
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit with hand-computed products; signed cases under MUL_SIGNED_EN.
module tb_mul_seq_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errs   = 0;

    mul_seq_unit_if #(.WIDTH(32)) bus ();

    mul_seq_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a multiply, scrambles operands after acceptance, and checks latency and result.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp);
        logic bad;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dataA     = a;
        bus.dataB     = b;
        bus.is_signed = s;
        tick();
        bus.start     = 1'b0;
        bus.dataA     = ~a;
        bus.dataB     = ~b;
        bus.is_signed = ~s;
        bad = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (!bus.busy || bus.done) bad = 1'b1;
            tick();
        end
        check({tag, " busy_no_done_1_32"}, 64'(bad), 64'd0);
        check({tag, " done_c33"}, 64'({bus.busy, bus.done}), 64'd3);
        check({tag, " product"}, {bus.hi, bus.lo}, exp);
        tick();
        check({tag, " idle_c34"}, 64'({bus.busy, bus.done}), 64'd0);
        check({tag, " held_c34"}, {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic bad;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dataA     = '0;
        bus.dataB     = '0;
        rst = 1'b1;
        tick();
        tick();
        check("reset busy_done", 64'({bus.busy, bus.done}), 64'd0);
        check("reset hi_lo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;
        tick();

        run_mul("u3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        run_mul("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_mul("zero", 32'd0, 32'h1234_5678, 1'b0, 64'd0);

        // start held high: second multiply accepted at edge T0+34 with operands changed mid-run
        @(negedge clk);
        bus.start = 1'b1;
        bus.dataA = 32'd9;
        bus.dataB = 32'd9;
        bus.is_signed = 1'b0;
        tick();
        bus.dataA = 32'd10;
        bus.dataB = 32'd11;
        bad = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (!bus.busy || bus.done) bad = 1'b1;
            tick();
        end
        check("held first busy", 64'(bad), 64'd0);
        check("held first done", 64'({bus.busy, bus.done}), 64'd3);
        check("held first product", {bus.hi, bus.lo}, 64'd81);
        tick();
        check("held gap idle", 64'({bus.busy, bus.done}), 64'd0);
        tick();
        check("held second accepted", 64'({bus.busy, bus.done}), 64'd2);
        bus.start = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (!bus.busy || bus.done) bad = 1'b1;
            if (k > 1 && {bus.hi, bus.lo} != 64'd81) bad = 1'b1;
            tick();
        end
        check("held second busy_hold", 64'(bad), 64'd0);
        check("held second done", 64'({bus.busy, bus.done}), 64'd3);
        check("held second product", {bus.hi, bus.lo}, 64'd110);
        tick();

        // synchronous reset in cycle 10 of RUN aborts the multiply
        @(negedge clk);
        bus.start = 1'b1;
        bus.dataA = 32'd4;
        bus.dataB = 32'd4;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        check("abort busy_c10", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy_done", 64'({bus.busy, bus.done}), 64'd0);
        check("abort hi_lo", {bus.hi, bus.lo}, 64'd0);
        tick();
        check("abort stays idle", 64'({bus.busy, bus.done}), 64'd0);
        run_mul("u7x6", 32'd7, 32'd6, 1'b0, 64'd42);

`ifdef MUL_SIGNED_EN
        run_mul("s-3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        run_mul("s8x8", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run_mul("u8x8", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        run_mul("s-1x2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_mul("u-1x2", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
`else
        run_mul("nosign -1x2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'h0000_0001_FFFF_FFFE);
        run_mul("nosign 8x8", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
